// File: rtl/ecc_pkg.sv
// Shared types and sizing for the ECC write arbiter: FSM encoding, data/code widths
// and the Hamming check-bit masks used by the encoder.
package ecc_pkg;

  localparam int DW = 32;
  localparam int CW = 38;
  localparam int AW = 8;
  localparam int KW = CW - DW;

  // Inverted check-bit pattern so an all-zero data word does not encode to all zeros.
  localparam logic [KW-1:0] CHK_INV = 6'h15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Data bit d sits at the d-th non-power-of-two codeword position (1-based);
  // check bit k covers every data bit whose position has bit k set.
  function automatic logic [DW-1:0] chk_mask(input int k);
    logic [DW-1:0] m;
    int            d;
    m = '0;
    d = 0;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        m[d] = p[k];
        d++;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_enc_module.sv
// Combinational Hamming encoder: appends six check bits above the 32-bit data word.
module ecc_enc_module
  import ecc_pkg::*;
(
  input  logic [DW-1:0] data,
  output logic [CW-1:0] code
);

  logic [KW-1:0] chk;

  genvar gi;
  generate
    for (gi = 0; gi < KW; gi++) begin : g_chk
      localparam logic [DW-1:0] MASK = chk_mask(gi);
      assign chk[gi] = (^(data & MASK)) ^ CHK_INV[gi];
    end
  endgenerate

  assign code = {chk, data};

endmodule

// File: rtl/ecc_wr_arb.sv
// Two-requester round-robin write arbiter: grants one request, ECC-encodes its data,
// drives a memory write until ack or timeout, then pulses done to the granted side.
module ecc_wr_arb
  import ecc_pkg::*;
#(
  parameter int unsigned ACK_TO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [CW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic          err_clr,
  output logic          busy,
  output logic          err
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TO - 1);

  state_t        state_reg, state_next;
  logic          sel_reg;
  logic          last_reg;
  logic [AW-1:0] addr_lat_reg;
  logic [DW-1:0] data_lat_reg;
  logic [7:0]    cnt_reg;
  logic          err_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [CW-1:0] mem_wdata_reg;

  logic          grant_any;
  logic          grant_id;
  logic          timeout;
  logic [CW-1:0] code;

  ecc_enc_module u_enc (
    .data (data_lat_reg),
    .code (code)
  );

  always_comb begin
    state_next = state_reg;
    grant_any  = 1'b0;
    grant_id   = sel_reg;
    timeout    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_any  = 1'b1;
          // Contention goes to whoever was not served last.
          grant_id   = (req0 && req1) ? ~last_reg : req1;
          state_next = ST_ENC;
        end
      end
      ST_ENC:   state_next = ST_WRITE;
      ST_WRITE: begin
        if (mem_ack) begin
          state_next = ST_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= 1'b0;
      last_reg      <= 1'b1;
      addr_lat_reg  <= '0;
      data_lat_reg  <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_any) begin
        sel_reg      <= grant_id;
        addr_lat_reg <= grant_id ? addr1 : addr0;
        data_lat_reg <= grant_id ? data1 : data0;
      end
      if (state_reg == ST_ENC) begin
        mem_addr_reg  <= addr_lat_reg;
        mem_wdata_reg <= code;
      end
      cnt_reg <= (state_reg == ST_WRITE && state_next == ST_WRITE) ? cnt_reg + 8'd1 : 8'd0;
      if (state_reg == ST_DONE) begin
        last_reg <= sel_reg;
      end
      // A fresh timeout outranks a simultaneous clear.
      if (timeout) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  // Grant is decoded from IDLE, which reset forces, so it is masked while rst is high.
  assign gnt0      = grant_any && !grant_id && !rst;
  assign gnt1      = grant_any &&  grant_id && !rst;
  assign done0     = (state_reg == ST_DONE) && !sel_reg;
  assign done1     = (state_reg == ST_DONE) &&  sel_reg;
  assign mem_wr    = (state_reg == ST_WRITE);
  assign busy      = (state_reg != ST_IDLE);
  assign err       = err_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_ecc_wr_arb.sv
// Randomized self-checking bench for ecc_wr_arb against a transaction-level model
// of arbitration order, write latency, ECC word, timeout and error flag.
module tb_ecc_wr_arb;

  localparam int ACK_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  addr0, addr1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1, done0, done1;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [37:0] mem_wdata;
  logic        mem_ack, err_clr, busy, err;

  int tests_run    = 0;
  int tests_failed = 0;
  int txn_id       = 0;
  int last_m       = 1;
  bit err_m        = 1'b0;

  ecc_wr_arb #(.ACK_TO(ACK_TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .data0     (data0),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .err_clr   (err_clr),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference Hamming code: XOR of the codeword positions of all set data bits.
  function automatic logic [37:0] enc_ref(input logic [31:0] d);
    logic [5:0] syn;
    int         k;
    syn = '0;
    k   = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) syn = syn ^ 6'(p);
        k++;
      end
    end
    return {syn ^ 6'h15, d};
  endfunction

  // Called just after a falling edge while the DUT is idle; returns in the DONE
  // cycle, or in the following IDLE cycle when clr_after is set.
  task automatic run_write(input bit r0, input bit r1,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int ack_dly, input bit clr_after, input bit clr_during);
    int          exp_id, exp_w, wcnt;
    bit          tmo;
    logic [7:0]  exp_addr;
    logic [37:0] exp_word;
    exp_id   = (r0 && r1) ? ((last_m == 0) ? 1 : 0) : (r1 ? 1 : 0);
    exp_addr = (exp_id == 1) ? a1 : a0;
    exp_word = enc_ref((exp_id == 1) ? d1 : d0);
    tmo      = (ack_dly >= ACK_TO);
    exp_w    = tmo ? ACK_TO : ack_dly + 1;

    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; data0 = d0; data1 = d1;
    mem_ack = 1'b0; err_clr = 1'b0;
    #1;
    check_val("gnt0", 64'(gnt0), 64'(exp_id == 0));
    check_val("gnt1", 64'(gnt1), 64'(exp_id == 1));
    check_val("gnt_busy", 64'(busy), 64'd0);

    @(negedge clk);
    if (exp_id == 0) req0 = 1'b0; else req1 = 1'b0;
    err_clr = clr_during;
    #1;
    check_val("enc_mem_wr", 64'(mem_wr), 64'd0);
    check_val("enc_busy", 64'(busy), 64'd1);
    check_val("enc_gnt", 64'({gnt0, gnt1}), 64'd0);

    wcnt = 0;
    for (int i = 0; i < ACK_TO + 3; i++) begin
      @(negedge clk);
      mem_ack = (i == ack_dly);
      #1;
      if (!mem_wr) break;
      wcnt++;
      if (i == 0) begin
        check_val("mem_addr", 64'(mem_addr), 64'(exp_addr));
        check_val("mem_wdata", 64'(mem_wdata), 64'(exp_word));
      end
    end

    err_m = tmo ? 1'b1 : (clr_during ? 1'b0 : err_m);
    check_val("wr_cycles", 64'(wcnt), 64'(exp_w));
    check_val("done0", 64'(done0), 64'(exp_id == 0));
    check_val("done1", 64'(done1), 64'(exp_id == 1));
    check_val("done_gnt", 64'({gnt0, gnt1}), 64'd0);
    check_val("done_addr_hold", 64'(mem_addr), 64'(exp_addr));
    check_val("done_wdata_hold", 64'(mem_wdata), 64'(exp_word));
    check_val("err", 64'(err), 64'(err_m));
    mem_ack = 1'b0;
    err_clr = clr_after;
    last_m  = exp_id;
    $display("[TB] txn %0d req=%b%b gnt%0d addr=%02h word=%010h writes=%0d err=%0b",
             txn_id, r1, r0, exp_id, exp_addr, exp_word, wcnt, err_m);
    txn_id++;

    if (clr_after) begin
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      err_m = 1'b0;
      check_val("err_clr", 64'(err), 64'(err_m));
      check_val("clr_busy", 64'(busy), 64'd0);
    end
  endtask

  // Idle cycles with no requests; mem_ack toggles and must be ignored.
  task automatic idle_cycles(input int n, input bit force_ack);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      mem_ack = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check_val("idle_busy", 64'(busy), 64'd0);
      check_val("idle_out", 64'({gnt0, gnt1, done0, done1, mem_wr}), 64'd0);
      check_val("idle_err", 64'(err), 64'(err_m));
    end
  endtask

  task automatic reset_mid_write();
    req0 = 1'b1; req1 = 1'b0; addr0 = 8'($urandom); data0 = $urandom;
    mem_ack = 1'b0; err_clr = 1'b0;
    #1;
    check_val("rw_gnt0", 64'(gnt0), 64'(1));
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("rw_in_write", 64'(mem_wr), 64'd1);
    rst  = 1'b1;
    req0 = 1'b1;
    #1;
    check_val("rw_outs", 64'({mem_wr, busy, gnt0, gnt1, done0, done1, err}), 64'd0);
    check_val("rw_addr", 64'(mem_addr), 64'd0);
    check_val("rw_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    req0   = 1'b0;
    last_m = 1;
    err_m  = 1'b0;
    $display("[TB] txn %0d reset during WRITE", txn_id);
    txn_id++;
  endtask

  initial begin
    bit r0, r1;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    mem_ack = 1'b0; err_clr = 1'b0;

    @(negedge clk);
    #1;
    check_val("rst_outs", 64'({gnt0, gnt1, done0, done1, mem_wr, busy, err}), 64'd0);
    check_val("rst_addr", 64'(mem_addr), 64'd0);
    check_val("rst_wdata", 64'(mem_wdata), 64'd0);

    // Both requesters held out of reset: req0 first with zero data at 8'h10.
    @(negedge clk);
    rst = 1'b0;
    run_write(1'b1, 1'b1, 8'h10, 8'h22, 32'h0, 32'hdeadbeef, 2, 1'b0, 1'b0);
    @(negedge clk);
    run_write(1'b0, 1'b1, 8'h10, 8'h22, 32'h0, 32'hdeadbeef, 0, 1'b0, 1'b0);

    // Timeout then clear; ack exactly on the last allowed cycle.
    @(negedge clk);
    run_write(1'b1, 1'b0, 8'h3c, 8'h00, 32'h1234_5678, 32'h0, 9, 1'b1, 1'b0);
    @(negedge clk);
    run_write(1'b0, 1'b1, 8'h00, 8'h5a, 32'h0, 32'h8000_0001, ACK_TO - 1, 1'b0, 1'b0);

    // Clear held across a timeout: the timeout must win.
    @(negedge clk);
    run_write(1'b1, 1'b0, 8'h77, 8'h00, 32'hffff_ffff, 32'h0, 7, 1'b0, 1'b1);
    @(negedge clk);
    run_write(1'b0, 1'b1, 8'h00, 8'h81, 32'h0, 32'h0f0f_0f0f, 1, 1'b1, 1'b0);

    idle_cycles(3, 1'b1);

    @(negedge clk);
    reset_mid_write();
    run_write(1'b0, 1'b1, 8'h00, 8'hc3, 32'h0, 32'h0bad_cafe, 0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      idle_cycles($urandom_range(0, 2), 1'b0);
      @(negedge clk);
      run_write(r0, r1, 8'($urandom), 8'($urandom), $urandom, $urandom,
                $urandom_range(0, 5), (r0 ^ r1) && ($urandom_range(0, 3) == 0),
                $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ecc_wr_arb.md
ECC_WR_ARB -- requirements
Module: ecc_wr_arb

Interface
REQ-001 SHALL have parameter ACK_TO, default 255, meaning the number of WRITE-state cycles without mem_ack before timeout (range 1..255).
REQ-002 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, in, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports req0/req1, in, 1 each, write request; held high by the requester until its gnt.
REQ-005 SHALL have ports addr0/addr1, in, 8 each, write address, valid while req is high.
REQ-006 SHALL have ports data0/data1, in, 32 each, write data, valid while req is high.
REQ-007 SHALL have ports gnt0/gnt1, out, 1 each, one-cycle pulse; address and data are latched on this cycle.
REQ-008 SHALL have ports done0/done1, out, 1 each, one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port mem_wr, out, 1, memory write strobe.
REQ-010 SHALL have port mem_addr, out, 8, memory address.
REQ-011 SHALL have port mem_wdata, out, 38, encoded word: {6 check bits, 32 data bits}.
REQ-012 SHALL have port mem_ack, in, 1, memory write accept.
REQ-013 SHALL have port err_clr, in, 1, synchronous clear of err.
REQ-014 SHALL have ports busy, out, 1 (state not IDLE) and err, out, 1 (sticky timeout flag).

Function
REQ-015 SHALL implement the states IDLE, ENC, WRITE and DONE.
REQ-016 IDLE: if req0 or req1 is high, SHALL pulse the selected gnt, latch its addr/data and go to ENC next cycle; otherwise SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not served last; the last pointer resets to 1, so req0 wins first.
REQ-018 ENC: one cycle; SHALL register the encoder output into mem_wdata and the latched address into mem_addr, then go to WRITE.
REQ-019 WRITE: mem_wr SHALL be high; the counter SHALL increment each cycle; on mem_ack SHALL go to DONE with mem_wr low next cycle.
REQ-020 If the counter reaches ACK_TO without mem_ack, SHALL set err, drop mem_wr and go to DONE; if mem_ack arrives in the same cycle, ack wins and err is not set.
REQ-021 DONE: SHALL pulse done of the granted requester, update the last pointer and go to IDLE; a new grant SHALL be possible the following cycle.
REQ-022 Latency SHALL be: gnt at cycle N, mem_wr first high at N+2, done one cycle after the ack cycle; minimum 4 cycles per write.
REQ-023 mem_ack outside WRITE SHALL be ignored; a req dropped before gnt SHALL be ignored; a req held during another's service SHALL wait.
REQ-024 err SHALL stay set until err_clr or rst; err_clr coincident with a new timeout SHALL leave err set.
REQ-025 mem_addr and mem_wdata SHALL hold their values from ENC until the next ENC.

Reset
REQ-026 On rst, all outputs SHALL go to 0 immediately (asynchronously), including mid-WRITE; the state SHALL be IDLE, the counter 0 and the last pointer 1.
REQ-027 Latched address/data SHALL be cleared to 0; no pending done SHALL survive reset.

Structure
REQ-028 Package ecc_pkg SHALL hold the state encoding, DW=32, CW=38 and AW=8.
REQ-029 SHALL instantiate exactly one ecc_enc_module, combinational, fed from the latched data register.

Verification
REQ-030 Bench SHALL cover: req0, data0=0, addr0=8'h10, mem_ack 2 cycles after mem_wr -> gnt0, mem_addr=8'h10, mem_wdata=38'h15_0000_0000, done0.
REQ-031 Bench SHALL cover: req0 and req1 held together from reset -> gnt0 first, then gnt1; done0 precedes gnt1.
REQ-032 Bench SHALL cover: mem_ack never asserted, ACK_TO=4 -> mem_wr high 4 cycles, err=1, done pulse; err_clr -> err=0.
REQ-033 Bench SHALL cover: mem_ack on cycle ACK_TO exactly -> err stays 0.
REQ-034 Bench SHALL cover: rst asserted mid-WRITE -> mem_wr, busy, gnt and done 0 at once; after release req1 wins when only req1 is asserted.
REQ-035 Bench SHALL cover: mem_ack pulsed in IDLE -> no state change, no done.
